// File: rtl/systolic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_pkg: shared types and size helpers for the systolic sequencer|
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEFAULT_DIMENSION = 4;

  // A 1x1 array still needs a one-bit address/row index.
  function automatic int addr_bits(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  function automatic int t_bits(input int dim);
    return $clog2(3 * dim);
  endfunction

  function automatic int run_len(input int dim);
    return 3 * dim - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | skew_delay_line: DEPTH-stage register chain with async clear          |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_i;
      assign q_o = d_i;
    end else begin : g_chain
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_seq_ctrl: job sequencer for an output-stationary MAC array   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int DIMENSION = DEFAULT_DIMENSION,
  parameter int I_BITS    = 8,
  parameter int ADDR_BITS = addr_bits(DIMENSION),
  parameter int T_BITS    = t_bits(DIMENSION)
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [2:0]                  i_matrix_size,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_rd_en,
  output logic [ADDR_BITS-1:0]        o_rd_addr,
  input  logic [DIMENSION*I_BITS-1:0] i_a_col,
  input  logic [DIMENSION*I_BITS-1:0] i_b_row,
  output logic [DIMENSION*I_BITS-1:0] o_a_edge,
  output logic [DIMENSION*I_BITS-1:0] o_b_edge,
  output logic                        o_valid,
  output logic                        o_clr,
  output logic [2:0]                  o_matrix_size,
  output logic [2*DIMENSION-2:0]      o_cap_diag,
  output logic [ADDR_BITS-1:0]        o_res_row,
  output logic                        o_res_valid,
  input  logic                        i_res_ready
);

  localparam logic [T_BITS-1:0]    c_t_last   = T_BITS'(run_len(DIMENSION) - 1);
  localparam logic [T_BITS-1:0]    c_t_feed   = T_BITS'(DIMENSION);
  localparam logic [T_BITS-1:0]    c_t_rdlast = T_BITS'(DIMENSION - 1);
  localparam logic [ADDR_BITS-1:0] c_r_last   = ADDR_BITS'(DIMENSION - 1);

  state_t               state_q, state_d;
  logic [T_BITS-1:0]    t_q, t_d;
  logic [ADDR_BITS-1:0] r_q, r_d;
  logic [2:0]           msize_q;
  logic                 feed;
  logic [DIMENSION*I_BITS-1:0] a_feed, b_feed;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      r_q     <= '0;
      msize_q <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      r_q     <= r_d;
      if (state_q == ST_IDLE && i_start) msize_q <= i_matrix_size;
    end
  end

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    r_d         = r_q;
    feed        = 1'b0;
    o_done      = 1'b0;
    o_rd_en     = 1'b0;
    o_rd_addr   = '0;
    o_valid     = 1'b0;
    o_clr       = 1'b0;
    o_res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        o_valid = 1'b1;
        o_clr   = 1'b1;
        o_rd_en = 1'b1;
        t_d     = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        o_valid = 1'b1;
        // Prefetch k=t+1 so column k arrives exactly at t=k.
        if (t_q < c_t_rdlast) begin
          o_rd_en   = 1'b1;
          o_rd_addr = t_q[ADDR_BITS-1:0] + ADDR_BITS'(1);
        end
        feed = (t_q < c_t_feed);
        if (t_q == c_t_last) begin
          r_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          t_d = t_q + T_BITS'(1);
        end
      end
      ST_DRAIN: begin
        o_res_valid = 1'b1;
        if (i_res_ready) begin
          if (r_q == c_r_last) state_d = ST_DONE;
          else                 r_d = r_q + ADDR_BITS'(1);
        end
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy        = (state_q != ST_IDLE);
  assign o_matrix_size = msize_q;
  assign o_res_row     = r_q;
  assign a_feed        = feed ? i_a_col : '0;
  assign b_feed        = feed ? i_b_row : '0;

  // Diagonal d finishes its last MAC at t=d+DIMENSION-1; capture one cycle later.
  generate
    for (genvar d = 0; d < 2*DIMENSION-1; d++) begin : g_cap
      assign o_cap_diag[d] = (state_q == ST_RUN) && (t_q == T_BITS'(d + DIMENSION));
    end

    for (genvar l = 0; l < DIMENSION; l++) begin : g_lane
      skew_delay_line #(.WIDTH(I_BITS), .DEPTH(l)) u_a_skew (
        .clk_i (i_clock),
        .rst_i (i_reset),
        .d_i   (a_feed[l*I_BITS +: I_BITS]),
        .q_o   (o_a_edge[l*I_BITS +: I_BITS])
      );
      skew_delay_line #(.WIDTH(I_BITS), .DEPTH(l)) u_b_skew (
        .clk_i (i_clock),
        .rst_i (i_reset),
        .d_i   (b_feed[l*I_BITS +: I_BITS]),
        .q_o   (o_b_edge[l*I_BITS +: I_BITS])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_systolic_seq_ctrl: directed self-checking bench for the sequencer  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_systolic_seq_ctrl;

  localparam int D = 4;
  localparam int W = 8;
  localparam int AB = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_start = 1'b0;
  logic [2:0]       i_matrix_size = 3'd0;
  logic             o_busy, o_done, o_rd_en, o_valid, o_clr, o_res_valid;
  logic [AB-1:0]    o_rd_addr, o_res_row;
  logic [D*W-1:0]   a_col = '0, b_row = '0, o_a_edge, o_b_edge;
  logic [2:0]       o_matrix_size;
  logic [2*D-2:0]   o_cap_diag;
  logic             i_res_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [W-1:0] A [D][D];
  logic signed [W-1:0] B [D][D];

  int          a_hist [16][D];
  int          b_hist [16][D];
  logic [2*D-2:0] cap_hist [16];
  int run_t, first_res, done_cyc, done_cnt, n_xfer, n_drain, cyc;
  int xfer_row [8];
  int drain_row [32];
  logic drain_rdy [32];

  systolic_seq_ctrl #(.DIMENSION(D), .I_BITS(W)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_start       (i_start),
    .i_matrix_size (i_matrix_size),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_rd_en       (o_rd_en),
    .o_rd_addr     (o_rd_addr),
    .i_a_col       (a_col),
    .i_b_row       (b_row),
    .o_a_edge      (o_a_edge),
    .o_b_edge      (o_b_edge),
    .o_valid       (o_valid),
    .o_clr         (o_clr),
    .o_matrix_size (o_matrix_size),
    .o_cap_diag    (o_cap_diag),
    .o_res_row     (o_res_row),
    .o_res_valid   (o_res_valid),
    .i_res_ready   (i_res_ready)
  );

  always #5 clk = ~clk;

  // Synchronous operand memories, one-cycle read latency.
  always @(posedge clk) begin
    if (o_rd_en) begin
      for (int r = 0; r < D; r++) begin
        a_col[r*W +: W] <= A[r][o_rd_addr];
        b_row[r*W +: W] <= B[o_rd_addr][r];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Product of A and B, the result an ideal array must accumulate.
  function automatic int ref_c(input int i, input int j);
    int s = 0;
    for (int k = 0; k < D; k++) s += int'(A[i][k]) * int'(B[k][j]);
    return s;
  endfunction

  // Array model: PE(i,j) sees A lane i delayed j hops and B lane j delayed i hops.
  function automatic int model_c(input int i, input int j);
    int s = 0;
    for (int t = i + j; t < i + j + D; t++) s += a_hist[t-j][i] * b_hist[t-i][j];
    return s;
  endfunction

  task automatic start_job(input logic [2:0] ms);
    i_start = 1'b1;
    i_matrix_size = ms;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Entered one step after the start edge (the CLEAR cycle is cycle 1).
  task automatic collect(input bit bp, input int pulse_cyc, input int tail);
    cyc = 1; run_t = 0; first_res = -1; done_cyc = -1; done_cnt = 0; n_xfer = 0; n_drain = 0;
    for (int t = 0; t < 16; t++) begin
      cap_hist[t] = '0;
      for (int l = 0; l < D; l++) begin a_hist[t][l] = 0; b_hist[t][l] = 0; end
    end
    while (cyc < 60) begin
      i_res_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (pulse_cyc >= 0) begin
        i_start = (cyc == pulse_cyc);
        if (cyc == pulse_cyc) i_matrix_size = 3'd5;
      end
      #1;
      if (o_valid && !o_clr && run_t < 16) begin
        for (int l = 0; l < D; l++) begin
          a_hist[run_t][l] = int'($signed(o_a_edge[l*W +: W]));
          b_hist[run_t][l] = int'($signed(o_b_edge[l*W +: W]));
        end
        cap_hist[run_t] = o_cap_diag;
        run_t++;
      end
      if (o_res_valid) begin
        if (first_res < 0) first_res = cyc;
        if (n_drain < 32) begin
          drain_row[n_drain] = int'(o_res_row);
          drain_rdy[n_drain] = i_res_ready;
          n_drain++;
        end
        if (i_res_ready && n_xfer < 8) begin xfer_row[n_xfer] = int'(o_res_row); n_xfer++; end
      end
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + tail) break;
      @(posedge clk); #1;
      cyc++;
    end
    if (pulse_cyc >= 0) i_start = 1'b0;
    i_res_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_checks++; if ({o_done, o_rd_en, o_valid, o_clr, o_res_valid} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00000", {o_done, o_rd_en, o_valid, o_clr, o_res_valid}); end
    n_checks++; if ({o_a_edge, o_b_edge} !== '0) begin n_fail++; $display("FAIL reset_edges: got %h expected 0", {o_a_edge, o_b_edge}); end
    n_checks++; if (o_cap_diag !== '0) begin n_fail++; $display("FAIL reset_cap: got %b expected 0", o_cap_diag); end
    n_checks++; if ({o_matrix_size, o_rd_addr, o_res_row} !== '0) begin n_fail++; $display("FAIL reset_fields: got %h expected 0", {o_matrix_size, o_rd_addr, o_res_row}); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_identity;
    for (int r = 0; r < D; r++)
      for (int k = 0; k < D; k++) begin
        A[r][k] = (r == k) ? 8'sd1 : 8'sd0;
        B[r][k] = W'(r * 4 + k + 1);
      end
    start_job(3'd2);
    n_checks++; if ({o_clr, o_valid, o_rd_en} !== 3'b111) begin n_fail++; $display("FAIL clear_strobes: got %b expected 111", {o_clr, o_valid, o_rd_en}); end
    n_checks++; if (o_rd_addr !== 2'd0) begin n_fail++; $display("FAIL clear_addr: got %0d expected 0", o_rd_addr); end
    n_checks++; if (o_a_edge !== '0) begin n_fail++; $display("FAIL clear_edge: got %h expected 0", o_a_edge); end
    n_checks++; if (o_matrix_size !== 3'd2) begin n_fail++; $display("FAIL clear_msize: got %0d expected 2", o_matrix_size); end
    collect(1'b0, -1, 2);
    n_checks++; if (run_t !== 11) begin n_fail++; $display("FAIL run_len: got %0d expected 11", run_t); end
    n_checks++; if (first_res !== 13) begin n_fail++; $display("FAIL id_first_res: got %0d expected 13", first_res); end
    n_checks++; if (done_cyc !== 17) begin n_fail++; $display("FAIL id_done_cycle: got %0d expected 17", done_cyc); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL id_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (n_xfer !== 4) begin n_fail++; $display("FAIL id_xfers: got %0d expected 4", n_xfer); end
    for (int n = 0; n < 4; n++) begin
      n_checks++; if (xfer_row[n] !== n) begin n_fail++; $display("FAIL id_row%0d: got %0d expected %0d", n, xfer_row[n], n); end
    end
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        n_checks++; if (model_c(i, j) !== int'(B[i][j])) begin n_fail++; $display("FAIL id_c[%0d][%0d]: got %0d expected %0d", i, j, model_c(i, j), int'(B[i][j])); end
      end
    for (int t = 0; t < 11; t++) begin
      logic [2*D-2:0] e;
      e = '0;
      if (t >= D) e[t-D] = 1'b1;
      n_checks++; if (cap_hist[t] !== e) begin n_fail++; $display("FAIL cap_t%0d: got %b expected %b", t, cap_hist[t], e); end
    end
  endtask

  task automatic test_skew;
    for (int r = 0; r < D; r++)
      for (int k = 0; k < D; k++) begin
        A[r][k] = W'(r * 4 + k);
        B[r][k] = (r == k) ? 8'sd3 : -8'sd1;
      end
    start_job(3'd1);
    collect(1'b0, -1, 1);
    for (int t = 0; t < 11; t++) begin
      int e;
      e = (t >= 2 && t <= 5) ? 8 + t - 2 : 0;
      n_checks++; if (a_hist[t][2] !== e) begin n_fail++; $display("FAIL skew_lane2_t%0d: got %0d expected %0d", t, a_hist[t][2], e); end
    end
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        n_checks++; if (model_c(i, j) !== ref_c(i, j)) begin n_fail++; $display("FAIL skew_c[%0d][%0d]: got %0d expected %0d", i, j, model_c(i, j), ref_c(i, j)); end
      end
  endtask

  task automatic test_backpressure;
    for (int r = 0; r < D; r++)
      for (int k = 0; k < D; k++) begin
        A[r][k] = W'(r - k);
        B[r][k] = W'(k + 2);
      end
    start_job(3'd0);
    collect(1'b1, -1, 1);
    n_checks++; if (n_xfer !== 4) begin n_fail++; $display("FAIL bp_xfers: got %0d expected 4", n_xfer); end
    for (int n = 0; n < 4; n++) begin
      n_checks++; if (xfer_row[n] !== n) begin n_fail++; $display("FAIL bp_row%0d: got %0d expected %0d", n, xfer_row[n], n); end
    end
    n_checks++; if (n_drain !== 8) begin n_fail++; $display("FAIL bp_drain_cycles: got %0d expected 8", n_drain); end
    for (int n = 1; n < n_drain; n++) begin
      if (!drain_rdy[n-1]) begin
        n_checks++; if (drain_row[n] !== drain_row[n-1]) begin n_fail++; $display("FAIL bp_hold%0d: got %0d expected %0d", n, drain_row[n], drain_row[n-1]); end
      end
    end
    n_checks++; if (done_cyc !== 21) begin n_fail++; $display("FAIL bp_done_cycle: got %0d expected 21", done_cyc); end
  endtask

  task automatic test_start_busy;
    start_job(3'd3);
    collect(1'b0, 6, 3);
    n_checks++; if (o_matrix_size !== 3'd3) begin n_fail++; $display("FAIL busy_msize: got %0d expected 3", o_matrix_size); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (done_cyc !== 17) begin n_fail++; $display("FAIL busy_done_cycle: got %0d expected 17", done_cyc); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle_after: got %b expected 0", o_busy); end
  endtask

  task automatic test_reset_mid_run;
    start_job(3'd6);
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (o_cap_diag !== 7'b0000010) begin n_fail++; $display("FAIL mid_cap_t5: got %b expected 0000010", o_cap_diag); end
    rst = 1'b1;
    #1;
    n_checks++; if ({o_valid, o_clr, o_res_valid, o_busy} !== 4'b0) begin n_fail++; $display("FAIL mid_async_drop: got %b expected 0000", {o_valid, o_clr, o_res_valid, o_busy}); end
    n_checks++; if ({o_cap_diag, o_a_edge, o_b_edge} !== '0) begin n_fail++; $display("FAIL mid_async_edges: got %h expected 0", {o_cap_diag, o_a_edge, o_b_edge}); end
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if ({o_busy, o_rd_en, o_done, o_matrix_size} !== 6'b0) begin n_fail++; $display("FAIL mid_idle: got %b expected 000000", {o_busy, o_rd_en, o_done, o_matrix_size}); end
    @(posedge clk); #1;
    for (int r = 0; r < D; r++)
      for (int k = 0; k < D; k++) begin A[r][k] = 8'sh40; B[r][k] = 8'sh40; end
    start_job(3'd4);
    n_checks++; if (o_clr !== 1'b1) begin n_fail++; $display("FAIL mid_restart_clear: got %b expected 1", o_clr); end
    collect(1'b0, -1, 1);
    n_checks++; if (done_cyc !== 17) begin n_fail++; $display("FAIL mid_done_cycle: got %0d expected 17", done_cyc); end
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        n_checks++; if (model_c(i, j) !== 16384) begin n_fail++; $display("FAIL mid_c[%0d][%0d]: got %0d expected 16384", i, j, model_c(i, j)); end
      end
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < D; r++)
      for (int k = 0; k < D; k++) begin A[r][k] = W'(k + 1); B[r][k] = W'(r); end
    i_start = 1'b1;
    i_matrix_size = 3'd1;
    @(posedge clk); #1;
    collect(1'b0, -1, 0);
    n_checks++; if (done_cyc !== 17) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected 17", done_cyc); end
    for (int r = 0; r < D; r++)
      for (int k = 0; k < D; k++) begin A[r][k] = W'(r * k - 2); B[r][k] = W'(5 - r - k); end
    @(posedge clk); #1;
    n_checks++; if ({o_busy, o_done} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle_gap: got %b expected 00", {o_busy, o_done}); end
    @(posedge clk); #1;
    n_checks++; if (o_clr !== 1'b1) begin n_fail++; $display("FAIL b2b_second_clear: got %b expected 1", o_clr); end
    i_start = 1'b0;
    collect(1'b0, -1, 1);
    n_checks++; if (first_res !== 13) begin n_fail++; $display("FAIL b2b_first_res: got %0d expected 13", first_res); end
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        n_checks++; if (model_c(i, j) !== ref_c(i, j)) begin n_fail++; $display("FAIL b2b_c[%0d][%0d]: got %0d expected %0d", i, j, model_c(i, j), ref_c(i, j)); end
      end
  endtask

  initial begin
    for (int r = 0; r < D; r++)
      for (int k = 0; k < D; k++) begin A[r][k] = '0; B[r][k] = '0; end
    test_reset;
    test_identity;
    test_skew;
    test_backpressure;
    test_start_busy;
    test_reset_mid_run;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
